mv_to_bcd_fmt: RTL and testbench

Sequential formatter that turns an unsigned 16-bit millivolt measurement into the four BCD digits and decimal-point mask used by the 4-digit seven-segment controller (`x[15:0]`, `x_dp[3:0]`). It sits directly upstream of `seg7_ctrl`, between the measurement/averaging path and the display. It converts with an iterative double-dabble (shift-and-add-3) state machine, picks the display range automatically, and flags over-range. Its outputs are held stable between conversions so the display controller can sample them at any time.

---
 rtl/mv_to_bcd_fmt.sv | 165 ++++++++++++++++
 tb/tb_mv_to_bcd_fmt.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/mv_to_bcd_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : mv_to_bcd_fmt
//  Purpose  : Converts an unsigned 16-bit millivolt value into four BCD digits
//             plus a decimal-point mask for a 4-digit seven-segment display.
//             Binary-to-BCD uses an iterative double-dabble (shift-and-add-3)
//             engine. The display range is selected automatically
//             ("x.xxx V" or "xx.xx V"). Values at or above OVR_MV are flagged
//             as over-range and shown blank.
//  Ports    : clk       - system clock
//             rst_n     - asynchronous active-low reset
//             start     - one-cycle convert request, ignored while busy
//             value_mv  - measurement in mV, sampled on the accepting edge
//             bcd       - four BCD digits, [15:12] is the leftmost digit
//             bcd_dp    - decimal-point mask, bit 3 is the leftmost digit
//             range_hi  - 0: x.xxx V, 1: xx.xx V
//             ovf       - last accepted value was >= OVR_MV
//             busy      - conversion in progress
//             done      - one-cycle pulse when new outputs are valid
//  Revision : 1.0 - initial release
// ============================================================================
module mv_to_bcd_fmt #(
    parameter int unsigned OVR_MV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [15:0] value_mv,
    output logic [15:0] bcd,
    output logic [3:0]  bcd_dp,
    output logic        range_hi,
    output logic        ovf,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_FORMAT = 2'd2
    } state_t;

    localparam logic [4:0] c_LAST_SHIFT = 5'd15;

    state_t      r_state_q, w_state_d;
    logic [15:0] r_bin_q,   w_bin_d;
    logic [19:0] r_scr_q,   w_scr_d;
    logic [4:0]  r_cnt_q,   w_cnt_d;
    logic        r_ovr_q,   w_ovr_d;
    logic [15:0] r_bcd_q,   w_bcd_d;
    logic [3:0]  r_dp_q,    w_dp_d;
    logic        r_rng_q,   w_rng_d;
    logic        r_ovf_q,   w_ovf_d;
    logic        r_done_q,  w_done_d;

    // Scratch digits after the add-3 correction; each digit is handled
    // independently, so no carry ever crosses a digit boundary.
    logic [19:0] w_corr;

    always_comb begin
        w_corr = r_scr_q;
        for (int i = 0; i < 5; i++) begin
            if (r_scr_q[i*4 +: 4] >= 4'd5) begin
                w_corr[i*4 +: 4] = r_scr_q[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_bin_d   = r_bin_q;
        w_scr_d   = r_scr_q;
        w_cnt_d   = r_cnt_q;
        w_ovr_d   = r_ovr_q;
        w_bcd_d   = r_bcd_q;
        w_dp_d    = r_dp_q;
        w_rng_d   = r_rng_q;
        w_ovf_d   = r_ovf_q;
        w_done_d  = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (start) begin
                    w_bin_d   = value_mv;
                    w_scr_d   = 20'd0;
                    w_cnt_d   = 5'd0;
                    w_ovr_d   = ({16'd0, value_mv} >= OVR_MV);
                    w_state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                // {scratch, binary} shifted left by one as a single 36-bit word
                w_scr_d = {w_corr[18:0], r_bin_q[15]};
                w_bin_d = {r_bin_q[14:0], 1'b0};
                w_cnt_d = r_cnt_q + 5'd1;
                if (r_cnt_q == c_LAST_SHIFT) begin
                    w_state_d = ST_FORMAT;
                end
            end

            ST_FORMAT: begin
                if (r_ovr_q) begin
                    // All-ones digits are rendered blank by the display
                    w_bcd_d = 16'hFFFF;
                    w_dp_d  = 4'b0000;
                    w_rng_d = 1'b0;
                    w_ovf_d = 1'b1;
                end else if (r_scr_q[19:16] == 4'd0) begin
                    w_bcd_d = r_scr_q[15:0];
                    w_dp_d  = 4'b1000;
                    w_rng_d = 1'b0;
                    w_ovf_d = 1'b0;
                end else begin
                    // Drop the units-of-mV digit; truncation, not rounding
                    w_bcd_d = r_scr_q[19:4];
                    w_dp_d  = 4'b0100;
                    w_rng_d = 1'b1;
                    w_ovf_d = 1'b0;
                end
                w_done_d  = 1'b1;
                w_state_d = ST_IDLE;
            end

            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= ST_IDLE;
            r_bin_q   <= 16'd0;
            r_scr_q   <= 20'd0;
            r_cnt_q   <= 5'd0;
            r_ovr_q   <= 1'b0;
            r_bcd_q   <= 16'h0000;
            r_dp_q    <= 4'b0000;
            r_rng_q   <= 1'b0;
            r_ovf_q   <= 1'b0;
            r_done_q  <= 1'b0;
        end else begin
            r_state_q <= w_state_d;
            r_bin_q   <= w_bin_d;
            r_scr_q   <= w_scr_d;
            r_cnt_q   <= w_cnt_d;
            r_ovr_q   <= w_ovr_d;
            r_bcd_q   <= w_bcd_d;
            r_dp_q    <= w_dp_d;
            r_rng_q   <= w_rng_d;
            r_ovf_q   <= w_ovf_d;
            r_done_q  <= w_done_d;
        end
    end

    assign bcd      = r_bcd_q;
    assign bcd_dp   = r_dp_q;
    assign range_hi = r_rng_q;
    assign ovf      = r_ovf_q;
    assign done     = r_done_q;
    assign busy     = (r_state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mv_to_bcd_fmt.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mv_to_bcd_fmt
//  Purpose  : Directed plus random self-checking bench for mv_to_bcd_fmt.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mv_to_bcd_fmt;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] value_mv;
    logic [15:0] bcd;
    logic [3:0]  bcd_dp;
    logic        range_hi;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    mv_to_bcd_fmt #(.OVR_MV(50000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .value_mv (value_mv),
        .bcd      (bcd),
        .bcd_dp   (bcd_dp),
        .range_hi (range_hi),
        .ovf      (ovf),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pk(input logic [15:0] b, input logic [3:0] dp,
                                       input logic rng, input logic ov);
        return {10'd0, b, dp, rng, ov};
    endfunction

    function automatic logic [31:0] obs_out();
        return pk(bcd, bcd_dp, range_hi, ovf);
    endfunction

    // Reference formatter built from decimal division
    function automatic logic [31:0] ref_fmt(input int v);
        int w;
        logic [15:0] b;
        if (v >= 50000) return pk(16'hFFFF, 4'b0000, 1'b0, 1'b1);
        w = (v < 10000) ? v : v / 10;
        b = {4'((w / 1000) % 10), 4'((w / 100) % 10), 4'((w / 10) % 10), 4'(w % 10)};
        if (v < 10000) return pk(b, 4'b1000, 1'b0, 1'b0);
        return pk(b, 4'b0100, 1'b1, 1'b0);
    endfunction

    // Called at the negedge right after the accepting edge. Returns the edge
    // count from acceptance to done (-1 on timeout) and busy-high cycles.
    task automatic wait_done(output int lat, output int bcnt);
        lat  = -1;
        bcnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (busy) bcnt++;
            if (done) begin
                lat = n - 1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pulses start with v, scrambles value_mv afterwards, waits for done.
    task automatic run_conv(input logic [15:0] v, output int lat, output int bcnt);
        start    = 1'b1;
        value_mv = v;
        @(negedge clk);
        start    = 1'b0;
        value_mv = ~v;
        wait_done(lat, bcnt);
    endtask

    // Directed conversion with full checking of outputs, latency and pulse width
    task automatic conv_chk(input string tag, input logic [15:0] v, input logic [31:0] exp);
        int lat, bcnt;
        run_conv(v, lat, bcnt);
        chk({tag, "_lat"}, 32'(lat), 32'd17);
        chk({tag, "_busy"}, 32'(bcnt), 32'd17);
        chk({tag, "_out"}, obs_out(), exp);
        @(negedge clk);
        chk({tag, "_done1"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, obs_out(), exp);
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [15:0] rv;

        rst_n    = 1'b0;
        start    = 1'b0;
        value_mv = 16'd0;
        #1;
        chk("rst_out", obs_out(), 32'd0);
        chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_out", obs_out(), 32'd0);

        conv_chk("v0",     16'd0,     pk(16'h0000, 4'b1000, 1'b0, 1'b0));
        conv_chk("v1234",  16'd1234,  pk(16'h1234, 4'b1000, 1'b0, 1'b0));
        conv_chk("v9999",  16'd9999,  pk(16'h9999, 4'b1000, 1'b0, 1'b0));
        conv_chk("v10000", 16'd10000, pk(16'h1000, 4'b0100, 1'b1, 1'b0));
        conv_chk("v49999", 16'd49999, pk(16'h4999, 4'b0100, 1'b1, 1'b0));
        conv_chk("v50000", 16'd50000, pk(16'hFFFF, 4'b0000, 1'b0, 1'b1));
        conv_chk("v65535", 16'd65535, pk(16'hFFFF, 4'b0000, 1'b0, 1'b1));
        conv_chk("v42",    16'd42,    pk(16'h0042, 4'b1000, 1'b0, 1'b0));
        conv_chk("v5",     16'd5,     pk(16'h0005, 4'b1000, 1'b0, 1'b0));

        // Starts during busy are dropped; a start in the done cycle is taken
        start    = 1'b1;
        value_mv = 16'd3210;
        @(negedge clk);
        start    = 1'b0;
        value_mv = 16'd0;
        ndone    = 0;
        lat      = -1;
        for (int n = 1; n <= 40; n++) begin
            start    = (n == 5 || n == 10);
            value_mv = (n == 5 || n == 10) ? 16'd7777 : 16'd0;
            if (n == 12) chk("ign_hold", obs_out(), pk(16'h0005, 4'b1000, 1'b0, 1'b0));
            if (done) begin
                ndone++;
                lat = n - 1;
                break;
            end
            @(negedge clk);
        end
        chk("ign_lat", 32'(lat), 32'd17);
        chk("ign_ndone", 32'(ndone), 32'd1);
        chk("ign_out", obs_out(), pk(16'h3210, 4'b1000, 1'b0, 1'b0));
        start    = 1'b1;
        value_mv = 16'd7777;
        @(negedge clk);
        start    = 1'b0;
        value_mv = 16'd0;
        wait_done(lat, bcnt);
        chk("dcyc_lat", 32'(lat), 32'd17);
        chk("dcyc_out", obs_out(), pk(16'h7777, 4'b1000, 1'b0, 1'b0));
        @(negedge clk);

        // Asynchronous reset in the middle of a conversion
        start    = 1'b1;
        value_mv = 16'd8888;
        @(negedge clk);
        start    = 1'b0;
        repeat (7) @(negedge clk);
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out", obs_out(), 32'd0);
        chk("mid_rst_busy_done", {30'd0, busy, done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mid_rst_quiet", 32'(ndone), 32'd0);
        chk("mid_rst_hold", obs_out(), 32'd0);
        conv_chk("post_rst", 16'd20480, pk(16'h2048, 4'b0100, 1'b1, 1'b0));

        // Random sweep against the reference formatter
        for (int i = 0; i < 1000; i++) begin
            rv = 16'($urandom_range(0, 65535));
            run_conv(rv, lat, bcnt);
            chk("rnd_lat", 32'(lat), 32'd17);
            chk("rnd_out", obs_out(), ref_fmt(int'(rv)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
